// File: rtl/apb_mem_slave.sv
// APB completer backed by a MEM_DEPTH x 8 byte array, with programmable wait
// states and a slave error for addresses at or beyond MEM_DEPTH.
module apb_mem_slave #(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_DEPTH   = 192
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);

    // state  | meaning
    // IDLE   | waiting for a setup cycle
    // ACCESS | request latched, counting wait states down to completion
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] addr_q, wdata_q;
    logic       write_q, err_q;
    logic       latch, complete;
    logic       setup, addr_err;
    logic [7:0] mem [MEM_DEPTH];

    assign setup    = PSEL && !PENABLE;
    assign addr_err = ({1'b0, PADDR} >= 9'(MEM_DEPTH));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (setup) begin
                    latch     = 1'b1;
                    state_nxt = ACCESS;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (!PENABLE) begin
                    // Master restarted mid-transfer: drop the old request, take the new one.
                    latch     = 1'b1;
                    cnt_nxt   = 4'(WAIT_CYCLES);
                end else if (cnt != 4'd0) begin
                    cnt_nxt   = cnt - 4'd1;
                end else begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign PREADY  = (state == ACCESS) && (cnt == 4'd0);
    assign PSLVERR = PREADY && err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            PRDATA  <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
                write_q <= PWRITE;
                err_q   <= addr_err;
                if (!PWRITE)
                    PRDATA <= addr_err ? 8'd0 : mem[PADDR];
            end
        end
    end

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET && complete && write_q && !err_q)
            mem[addr_q] <= wdata_q;
    end

endmodule
